// File: rtl/multi_car_request_handler.sv
`default_nettype none
// ============================================================================
// Module      : multi_car_request_handler
// Description : Hall and cabin request queues shared by several elevator cars.
//               Button inputs are rising-edge detected (registered), queued,
//               and cleared by per-car strobes at the car's current floor.
//               Each hall request carries an age counter that raises a starve
//               flag once the request has waited AGE_LIMIT cycles.
//               Optional build macro REQ_CANCEL_EN: a second press on an
//               already pending cabin request cancels it (toggle).
// Revision    : 1.0 - initial release
// ============================================================================
module multi_car_request_handler #(
    parameter int N_FLOORS  = 12,
    parameter int N_CARS    = 2,
    parameter int AGE_W     = 8,
    parameter int AGE_LIMIT = 200
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_FLOORS-1:0]                 i_up_rqst,
    input  logic [N_FLOORS-1:0]                 i_dn_rqst,
    input  logic [N_CARS*N_FLOORS-1:0]          i_car_rqst,
    input  logic [N_CARS*N_FLOORS-1:0]          i_car_pos,
    input  logic [N_CARS-1:0]                   i_up_clr,
    input  logic [N_CARS-1:0]                   i_dn_clr,
    input  logic [N_CARS-1:0]                   i_car_clr,
    output logic [N_FLOORS-1:0]                 o_up_queue,
    output logic [N_FLOORS-1:0]                 o_dn_queue,
    output logic [N_CARS*N_FLOORS-1:0]          o_car_queue,
    output logic [N_FLOORS-1:0]                 o_up_starve,
    output logic [N_FLOORS-1:0]                 o_dn_starve,
    output logic [$clog2(2*N_FLOORS+1)-1:0]     o_hall_pending
);

    localparam int                 CAR_BITS = N_CARS * N_FLOORS;
    localparam int                 PEND_W   = $clog2(2 * N_FLOORS + 1);
    localparam logic [AGE_W-1:0]   AGE_MAX  = '1;
    localparam logic [AGE_W-1:0]   AGE_LIM  = AGE_W'(AGE_LIMIT);

    logic [N_FLOORS-1:0] up_prev, dn_prev, up_rise, dn_rise;
    logic [N_FLOORS-1:0] up_queue, dn_queue, up_next, dn_next;
    logic [N_FLOORS-1:0] up_clr_mask, dn_clr_mask;
    logic [CAR_BITS-1:0] car_prev, car_rise, car_queue, car_next, car_clr_mask;
    logic [PEND_W-1:0]   pending;

    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] v);
        return (v == AGE_MAX) ? v : v + AGE_W'(1);
    endfunction

    // Floors being served this cycle: every floor flagged in a strobing car's position
    always_comb begin
        up_clr_mask  = '0;
        dn_clr_mask  = '0;
        car_clr_mask = '0;
        for (int c = 0; c < N_CARS; c++) begin
            up_clr_mask = up_clr_mask |
                (i_car_pos[c*N_FLOORS +: N_FLOORS] & {N_FLOORS{i_up_clr[c]}});
            dn_clr_mask = dn_clr_mask |
                (i_car_pos[c*N_FLOORS +: N_FLOORS] & {N_FLOORS{i_dn_clr[c]}});
            car_clr_mask[c*N_FLOORS +: N_FLOORS] =
                i_car_pos[c*N_FLOORS +: N_FLOORS] & {N_FLOORS{i_car_clr[c]}};
        end
    end

    // Next queue contents: a clear at the landing always beats a new press
    always_comb begin
        up_next = (up_queue | up_rise) & ~up_clr_mask;
        dn_next = (dn_queue | dn_rise) & ~dn_clr_mask;
`ifdef REQ_CANCEL_EN
        car_next = (car_queue ^ car_rise) & ~car_clr_mask;
`else
        car_next = (car_queue | car_rise) & ~car_clr_mask;
`endif
    end

    // Registered edge detect; a press arriving while its floor is being served is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_prev  <= '0;
            dn_prev  <= '0;
            car_prev <= '0;
            up_rise  <= '0;
            dn_rise  <= '0;
            car_rise <= '0;
        end else begin
            up_prev  <= i_up_rqst;
            dn_prev  <= i_dn_rqst;
            car_prev <= i_car_rqst;
            up_rise  <= i_up_rqst  & ~up_prev  & ~up_clr_mask;
            dn_rise  <= i_dn_rqst  & ~dn_prev  & ~dn_clr_mask;
            car_rise <= i_car_rqst & ~car_prev & ~car_clr_mask;
        end
    end

    // Queue registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_queue  <= '0;
            dn_queue  <= '0;
            car_queue <= '0;
        end else begin
            up_queue  <= up_next;
            dn_queue  <= dn_next;
            car_queue <= car_next;
        end
    end

    // Per-floor hall age counters; restart from zero on the edge a request appears
    generate
        for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
            logic [AGE_W-1:0] up_age, dn_age;

            // Count while the request stays pending, zero otherwise
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    up_age <= '0;
                    dn_age <= '0;
                end else begin
                    up_age <= (up_next[f] && up_queue[f]) ? sat_inc(up_age) : '0;
                    dn_age <= (dn_next[f] && dn_queue[f]) ? sat_inc(dn_age) : '0;
                end
            end

            assign o_up_starve[f] = (up_age >= AGE_LIM);
            assign o_dn_starve[f] = (dn_age >= AGE_LIM);
        end
    endgenerate

    // Number of outstanding hall calls in both directions
    always_comb begin
        pending = '0;
        for (int f = 0; f < N_FLOORS; f++) begin
            pending = pending + PEND_W'(up_queue[f]) + PEND_W'(dn_queue[f]);
        end
    end

    assign o_up_queue     = up_queue;
    assign o_dn_queue     = dn_queue;
    assign o_car_queue    = car_queue;
    assign o_hall_pending = pending;

endmodule
`default_nettype wire

// File: tb/tb_multi_car_request_handler.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_car_request_handler
// Description : Directed, table-driven bench for multi_car_request_handler
//               with hand-written sequences for multi-cycle corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_car_request_handler;

    logic        clk;
    logic        reset;
    logic [11:0] up_rqst, dn_rqst;
    logic [23:0] car_rqst, car_pos;
    logic [1:0]  up_clr, dn_clr, car_clr;
    logic [11:0] up_queue, dn_queue, up_starve, dn_starve;
    logic [23:0] car_queue;
    logic [4:0]  hall_pending;

    int total = 0;
    int bad   = 0;

    multi_car_request_handler #(
        .N_FLOORS (12),
        .N_CARS   (2),
        .AGE_W    (8),
        .AGE_LIMIT(200)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_up_rqst     (up_rqst),
        .i_dn_rqst     (dn_rqst),
        .i_car_rqst    (car_rqst),
        .i_car_pos     (car_pos),
        .i_up_clr      (up_clr),
        .i_dn_clr      (dn_clr),
        .i_car_clr     (car_clr),
        .o_up_queue    (up_queue),
        .o_dn_queue    (dn_queue),
        .o_car_queue   (car_queue),
        .o_up_starve   (up_starve),
        .o_dn_starve   (dn_starve),
        .o_hall_pending(hall_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] up;
        logic [11:0] dn;
        logic [23:0] car;
        logic [23:0] pos;
        logic [1:0]  uclr;
        logic [1:0]  dclr;
        logic [1:0]  cclr;
        logic [11:0] e_up;
        logic [11:0] e_dn;
        logic [23:0] e_car;
        logic [4:0]  e_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [11:0] up, input logic [11:0] dn,
                       input logic [23:0] car, input logic [23:0] pos,
                       input logic [1:0] uclr, input logic [1:0] dclr,
                       input logic [1:0] cclr, input logic [11:0] e_up,
                       input logic [11:0] e_dn, input logic [23:0] e_car,
                       input logic [4:0] e_pend);
        vec_t v;
        v.up = up; v.dn = dn; v.car = car; v.pos = pos;
        v.uclr = uclr; v.dclr = dclr; v.cclr = cclr;
        v.e_up = e_up; v.e_dn = e_dn; v.e_car = e_car; v.e_pend = e_pend;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        up_rqst = '0; dn_rqst = '0; car_rqst = '0; car_pos = '0;
        up_clr = '0; dn_clr = '0; car_clr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("reset_up_queue", 64'(up_queue), 64'h0);
        chk("reset_pending",  64'(hall_pending), 64'h0);
        step();
        step();
        reset = 1'b0;

        // up, dn, car, pos, uclr, dclr, cclr | e_up, e_dn, e_car, e_pend
        add(12'h020, 12'h000, 24'h000000, 24'h000000, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 24'h000000, 5'd0);
        add(12'h020, 12'h000, 24'h000000, 24'h000000, 2'b00, 2'b00, 2'b00, 12'h020, 12'h000, 24'h000000, 5'd1);
        add(12'h020, 12'h000, 24'h000000, 24'h000000, 2'b00, 2'b00, 2'b00, 12'h020, 12'h000, 24'h000000, 5'd1);
        add(12'h000, 12'h008, 24'h000080, 24'h000000, 2'b00, 2'b00, 2'b00, 12'h020, 12'h000, 24'h000000, 5'd1);
        add(12'h000, 12'h008, 24'h000080, 24'h000000, 2'b00, 2'b00, 2'b00, 12'h020, 12'h008, 24'h000080, 5'd2);
        add(12'h000, 12'h000, 24'h000000, 24'h020004, 2'b10, 2'b00, 2'b00, 12'h000, 12'h008, 24'h000080, 5'd1);
        add(12'h000, 12'h000, 24'h020000, 24'h020004, 2'b00, 2'b00, 2'b00, 12'h000, 12'h008, 24'h000080, 5'd1);
        add(12'h000, 12'h000, 24'h000000, 24'h020004, 2'b00, 2'b00, 2'b01, 12'h000, 12'h008, 24'h020080, 5'd1);
        add(12'h000, 12'h000, 24'h000000, 24'h020004, 2'b00, 2'b00, 2'b10, 12'h000, 12'h008, 24'h000080, 5'd1);
        add(12'h000, 12'h000, 24'h000000, 24'h020088, 2'b00, 2'b01, 2'b01, 12'h000, 12'h000, 24'h000000, 5'd0);
        add(12'h801, 12'h000, 24'h000000, 24'h020000, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 24'h000000, 5'd0);
        add(12'h801, 12'h000, 24'h000000, 24'h020000, 2'b01, 2'b00, 2'b00, 12'h801, 12'h000, 24'h000000, 5'd2);
        add(12'h000, 12'hFFF, 24'h000000, 24'h000000, 2'b00, 2'b00, 2'b00, 12'h801, 12'h000, 24'h000000, 5'd2);
        add(12'h000, 12'hFFF, 24'h000000, 24'h000000, 2'b00, 2'b00, 2'b00, 12'h801, 12'hFFF, 24'h000000, 5'd14);
        add(12'h801, 12'h000, 24'h000000, 24'h000000, 2'b00, 2'b00, 2'b00, 12'h801, 12'hFFF, 24'h000000, 5'd14);
        add(12'h000, 12'h000, 24'h000000, 24'h000000, 2'b00, 2'b00, 2'b00, 12'h801, 12'hFFF, 24'h000000, 5'd14);

        foreach (vecs[i]) begin
            up_rqst  = vecs[i].up;
            dn_rqst  = vecs[i].dn;
            car_rqst = vecs[i].car;
            car_pos  = vecs[i].pos;
            up_clr   = vecs[i].uclr;
            dn_clr   = vecs[i].dclr;
            car_clr  = vecs[i].cclr;
            step();
            chk($sformatf("vec%0d_up", i),   64'(up_queue),     64'(vecs[i].e_up));
            chk($sformatf("vec%0d_dn", i),   64'(dn_queue),     64'(vecs[i].e_dn));
            chk($sformatf("vec%0d_car", i),  64'(car_queue),    64'(vecs[i].e_car));
            chk($sformatf("vec%0d_pend", i), 64'(hall_pending), 64'(vecs[i].e_pend));
        end

        // Press arriving while car 0 is serving floor 2: request never lands
        do_reset();
        car_pos  = 24'h000004;
        car_clr  = 2'b01;
        car_rqst = 24'h000004;
        step();
        step();
        chk("clear_wins_car", 64'(car_queue), 64'h0);
        car_clr = 2'b00;
        step();
        step();
        chk("clear_wins_held", 64'(car_queue), 64'h0);

        // Second press on a pending cabin request
        do_reset();
        car_rqst = 24'h000080; step();
        car_rqst = 24'h000000; step();
        chk("cabin_first_press", 64'(car_queue), 64'h80);
        car_rqst = 24'h000080; step();
        car_rqst = 24'h000000; step();
`ifdef REQ_CANCEL_EN
        chk("cabin_second_press", 64'(car_queue), 64'h0);
`else
        chk("cabin_second_press", 64'(car_queue), 64'h80);
`endif

        // Starvation flag timing on down call at floor 3
        do_reset();
        dn_rqst = 12'h008; step();
        dn_rqst = 12'h000; step();
        chk("starve_queue_set", 64'(dn_queue), 64'h008);
        chk("starve_initial",   64'(dn_starve), 64'h0);
        for (int k = 1; k < 200; k++) step();
        chk("starve_at_199", 64'(dn_starve), 64'h0);
        step();
        chk("starve_at_200", 64'(dn_starve), 64'h008);
        chk("starve_up_quiet", 64'(up_starve), 64'h0);
        car_pos = 24'h008000;   // car 1 at floor 3
        dn_clr  = 2'b10;
        step();
        chk("starve_clear_queue", 64'(dn_queue), 64'h0);
        chk("starve_clear_flag",  64'(dn_starve), 64'h0);
        idle_inputs();

        // Asynchronous reset with requests pending and a button held through it
        do_reset();
        up_rqst  = 12'h006;
        dn_rqst  = 12'h010;
        car_rqst = 24'h200000;
        step();
        step();
        chk("pre_reset_pending", 64'(hall_pending), 64'd3);
        chk("pre_reset_car",     64'(car_queue),    64'h200000);
        up_rqst  = 12'h002;
        dn_rqst  = 12'h000;
        car_rqst = 24'h000000;
        #3 reset = 1'b1;
        #1;
        chk("async_reset_up",   64'(up_queue),     64'h0);
        chk("async_reset_dn",   64'(dn_queue),     64'h0);
        chk("async_reset_car",  64'(car_queue),    64'h0);
        chk("async_reset_pend", 64'(hall_pending), 64'h0);
        step();
        up_rqst = 12'h042;      // press during reset
        step();
        up_rqst = 12'h002;
        step();
        chk("in_reset_up", 64'(up_queue), 64'h0);
        #2 reset = 1'b0;
        step();
        chk("post_reset_edge1", 64'(up_queue), 64'h0);
        step();
        chk("post_reset_edge2", 64'(up_queue), 64'h002);
        chk("post_reset_pend",  64'(hall_pending), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
